// File: rtl/spill_stack_pkg.sv
// Shared types for the spill stack: op decode, per-cell mux select and
// the count-width helper.
package spill_stack_pkg;

  // Encoded directly as {push, pop} so the decode is a plain cast.
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_ABOVE = 2'b01,
    SEL_BELOW = 2'b10,
    SEL_LOAD  = 2'b11
  } cell_sel_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/spill_stack_cell.sv
// One stack entry: a register with a hold / from_above / from_below / load
// next-value mux, steered by the shared decode in spill_stack.
module stack_cell
  import spill_stack_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] below,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      case (cell_sel_t'(sel))
        SEL_ABOVE: q <= above;
        SEL_BELOW: q <= below;
        SEL_LOAD:  q <= load;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/spill_stack.sv
// Fixed-depth push-down stack; pushing onto a full stack spills the bottom
// entry out through spill_data for one cycle.
module spill_stack
  import spill_stack_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] insert,
  input  logic             clear_err,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             spill_valid,
  output logic [WIDTH-1:0] spill_data,
  output logic             underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] entry [DEPTH];
  op_t              op;
  cell_sel_t        top_sel;
  cell_sel_t        shift_sel;
  logic [CW-1:0]    count_next;
  logic             set_uf;
  logic             spill_next;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count == '0);
  assign is_full  = (count == DEPTH_C);

  // Single decode: entry 0 may load in place (REPLACE), all others share one select.
  always_comb begin
    op         = op_t'({push, pop});
    top_sel    = SEL_HOLD;
    shift_sel  = SEL_HOLD;
    count_next = count;
    set_uf     = 1'b0;
    spill_next = 1'b0;
    case (op)
      OP_PUSH: begin
        top_sel   = SEL_ABOVE;
        shift_sel = SEL_ABOVE;
        if (is_full) spill_next = 1'b1;
        else         count_next = count + 1'b1;
      end
      OP_POP: begin
        if (is_empty) begin
          set_uf = 1'b1;
        end else begin
          top_sel    = SEL_BELOW;
          shift_sel  = SEL_BELOW;
          count_next = count - 1'b1;
        end
      end
      OP_REPLACE: begin
        if (is_empty) begin
          top_sel    = SEL_ABOVE;
          shift_sel  = SEL_ABOVE;
          count_next = CW'(1);
          set_uf     = 1'b1;
        end else begin
          top_sel = SEL_LOAD;
        end
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [WIDTH-1:0] above_d;
    logic [WIDTH-1:0] below_d;

    if (i == 0) begin : g_first
      assign above_d = insert;
    end else begin : g_rest
      assign above_d = entry[i-1];
    end

    // The bottom cell refills with zero so vacated slots never read stale data.
    if (i == DEPTH - 1) begin : g_last
      assign below_d = '0;
    end else begin : g_upper
      assign below_d = entry[i+1];
    end

    stack_cell #(.WIDTH(WIDTH)) u_cell (
      .clk   (clk),
      .reset (reset),
      .sel   ((i == 0) ? top_sel : shift_sel),
      .above (above_d),
      .below (below_d),
      .load  (insert),
      .q     (entry[i])
    );
  end

  assign top    = entry[0];
  assign second = entry[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      spill_valid <= 1'b0;
      spill_data  <= '0;
      underflow   <= 1'b0;
    end else begin
      count       <= count_next;
      empty       <= (count_next == '0);
      full        <= (count_next == DEPTH_C);
      spill_valid <= spill_next;
      if (spill_next) spill_data <= entry[DEPTH-1];
      underflow   <= set_uf | (underflow & ~clear_err);
    end
  end

endmodule
